// File: rtl/acquisition_scheduler.sv
// Acquisition sequencer: per transmit burst, skip a range-gate delay, gate ADC samples into
// storage, and after the programmed number of bursts hand the frame to the output interface.
module acquisition_scheduler #(
    parameter int DELAY_WIDTH    = 16,
    parameter int GATE_SCALE     = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   ENABLE,
    input  logic                   TX_START,
    input  logic                   SAMPLE_STB,
    input  logic [DELAY_WIDTH-1:0] GATE_DELAY,
    input  logic [7:0]             GATE_LENGTH,
    input  logic [7:0]             BURSTS,
    input  logic                   READY2WRITE,
    input  logic                   READY2READ,
    input  logic                   FRAME_DONE,
    output logic                   WRITE_EN,
    output logic                   READOUT_EN,
    output logic                   BUSY,
    output logic                   OVERRUN,
    output logic                   TIMEOUT,
    output logic [2:0]             STATE,
    output logic [7:0]             BURST_CNT
);

    localparam int SCALE_W = $clog2(GATE_SCALE);
    localparam int LEN_W   = 8 + SCALE_W + 1;
    localparam int CNT_W   = (DELAY_WIDTH > LEN_W) ? DELAY_WIDTH : LEN_W;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_TX = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_WAIT_RD = 3'd4,
        ST_READOUT = 3'd5
    } state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [DELAY_WIDTH-1:0] delay_reg, delay_next;
    logic [7:0]             length_reg, length_next;
    logic [7:0]             bursts_reg, bursts_next;
    logic [7:0]             burst_cnt_reg, burst_cnt_next;
    logic [WD_W-1:0]        wd_reg, wd_next;
    logic                   write_en_reg, write_en_next;
    logic                   readout_en_reg, readout_en_next;
    logic                   busy_reg, busy_next;
    logic                   overrun_reg, overrun_next;
    logic                   timeout_reg, timeout_next;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] gate_target;

    assign cnt_inc     = cnt_reg + CNT_W'(1);
    // Latched length is never zero, so the target is at least one GATE_SCALE unit.
    assign gate_target = CNT_W'(length_reg) << SCALE_W;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            delay_reg      <= '0;
            length_reg     <= '0;
            bursts_reg     <= '0;
            burst_cnt_reg  <= '0;
            wd_reg         <= '0;
            write_en_reg   <= 1'b0;
            readout_en_reg <= 1'b0;
            busy_reg       <= 1'b0;
            overrun_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            delay_reg      <= delay_next;
            length_reg     <= length_next;
            bursts_reg     <= bursts_next;
            burst_cnt_reg  <= burst_cnt_next;
            wd_reg         <= wd_next;
            write_en_reg   <= write_en_next;
            readout_en_reg <= readout_en_next;
            busy_reg       <= busy_next;
            overrun_reg    <= overrun_next;
            timeout_reg    <= timeout_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        delay_next     = delay_reg;
        length_next    = length_reg;
        bursts_next    = bursts_reg;
        burst_cnt_next = burst_cnt_reg;
        wd_next        = wd_reg;
        overrun_next   = overrun_reg;
        timeout_next   = timeout_reg;
        write_en_next  = 1'b0;

        if (!ENABLE) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    overrun_next   = 1'b0;
                    timeout_next   = 1'b0;
                    burst_cnt_next = '0;
                    state_next     = ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (TX_START) begin
                        delay_next  = GATE_DELAY;
                        length_next = (GATE_LENGTH == 8'd0) ? 8'd1 : GATE_LENGTH;
                        bursts_next = (BURSTS == 8'd0) ? 8'd1 : BURSTS;
                        cnt_next    = '0;
                        state_next  = (GATE_DELAY == '0) ? ST_CAPTURE : ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (TX_START)
                        overrun_next = 1'b1;
                    if (SAMPLE_STB) begin
                        if (cnt_inc == CNT_W'(delay_reg)) begin
                            cnt_next   = '0;
                            state_next = ST_CAPTURE;
                        end else begin
                            cnt_next = cnt_inc;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (TX_START)
                        overrun_next = 1'b1;
                    if (SAMPLE_STB) begin
                        cnt_next = cnt_inc;
                        if (READY2WRITE)
                            write_en_next = 1'b1;
                        else
                            overrun_next = 1'b1;
                        if (cnt_inc == gate_target) begin
                            burst_cnt_next = burst_cnt_reg + 8'd1;
                            state_next = ((burst_cnt_reg + 8'd1) == bursts_reg) ? ST_WAIT_RD : ST_WAIT_TX;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (READY2READ) begin
                        wd_next    = '0;
                        state_next = ST_READOUT;
                    end
                end
                ST_READOUT: begin
                    wd_next = wd_reg + WD_W'(1);
                    if (FRAME_DONE) begin
                        burst_cnt_next = '0;
                        state_next     = ST_WAIT_TX;
                    end else if (wd_reg == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_next = 1'b1;
                        state_next   = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // Registered outputs track the state being entered so they align with STATE.
        readout_en_next = (state_next == ST_READOUT);
        busy_next       = (state_next != ST_IDLE) && (state_next != ST_WAIT_TX);
    end

    assign WRITE_EN   = write_en_reg;
    assign READOUT_EN = readout_en_reg;
    assign BUSY       = busy_reg;
    assign OVERRUN    = overrun_reg;
    assign TIMEOUT    = timeout_reg;
    assign STATE      = state_reg;
    assign BURST_CNT  = burst_cnt_reg;

endmodule
